// File: rtl/mips_mem_port_arbiter.sv
// mips_mem_port_arbiter
// Shares the single memory port of the MIPS32 pipeline between instruction
// fetch (IF) and data access (MEM). Data access wins arbitration. A streak
// counter makes sure a waiting fetch is served after at most MAX_D_STREAK
// consecutive data grants.
// Each access holds the port for at least three cycles:
//   grant (IDLE) -> BUSY_x until m_ack -> RESP (ready pulse) -> IDLE.
// Optional build macro MEM_ARB_STATS_EN adds two 16-bit saturating
// counters: conflict_cnt_o and fetch_stall_cnt_o.
module mips_mem_port_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int STREAK_W     = 3
) (
    input  logic          clk1_i,
    input  logic          rst_n_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ready_o,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_stall_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ready_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_stall_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic          m_ack_i,
    input  logic [DW-1:0] m_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt_o,
    output logic [15:0]   fetch_stall_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = STREAK_W'(0);

    logic [1:0]          state_q,    state_d;
    logic [STREAK_W-1:0] streak_q,   streak_d;
    logic                m_req_q,    m_req_d;
    logic                m_we_q,     m_we_d;
    logic [AW-1:0]       m_addr_q,   m_addr_d;
    logic [DW-1:0]       m_wdata_q,  m_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic                d_ready_q,  d_ready_d;
    logic [DW-1:0]       d_rdata_q,  d_rdata_d;
    logic                grant_d_s;

    // Data wins unless a fetch is waiting and the data streak is used up.
    assign grant_d_s = d_req_i & (~if_req_i | (streak_q < STREAK_MAX));

    // Next-state, grant capture and response capture.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ready_d = 1'b0;
        if_rdata_d = if_rdata_q;
        d_ready_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d   = ST_BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                    if (if_req_i) begin
                        if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + STREAK_ONE;
                        end else begin
                            streak_d = streak_q;
                        end
                    end else begin
                        streak_d = STREAK_ZERO;
                    end
                end else if (if_req_i) begin
                    state_d   = ST_BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr_i;
                    m_wdata_d = {DW{1'b0}};
                    streak_d  = STREAK_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (m_ack_i) begin
                    state_d    = ST_RESP;
                    m_req_d    = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = m_rdata_i;
                end else begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                if (m_ack_i) begin
                    state_d   = ST_RESP;
                    m_req_d   = 1'b0;
                    d_ready_d = 1'b1;
                    // Stores leave the load-data register untouched.
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata_i;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = ST_BUSY_D;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk1_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            streak_q   <= STREAK_ZERO;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= {AW{1'b0}};
            m_wdata_q  <= {DW{1'b0}};
            if_ready_q <= 1'b0;
            if_rdata_q <= {DW{1'b0}};
            d_ready_q  <= 1'b0;
            d_rdata_q  <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ready_q <= if_ready_d;
            if_rdata_q <= if_rdata_d;
            d_ready_q  <= d_ready_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_req_o    = m_req_q;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign if_ready_o = if_ready_q;
    assign if_rdata_o = if_rdata_q;
    assign d_ready_o  = d_ready_q;
    assign d_rdata_o  = d_rdata_q;

    // Stalls must react in the same cycle the pipeline raises a request.
    assign if_stall_o = if_req_i & ~if_ready_q;
    assign d_stall_o  = d_req_i & ~d_ready_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q,    conflict_cnt_d;
    logic [15:0] fetch_stall_cnt_q, fetch_stall_cnt_d;

    // Saturating event counters: arbitration conflicts and fetch stall cycles.
    always_comb begin
        conflict_cnt_d    = conflict_cnt_q;
        fetch_stall_cnt_d = fetch_stall_cnt_q;
        if ((state_q == ST_IDLE) && if_req_i && d_req_i && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
        if (if_stall_o && (fetch_stall_cnt_q != 16'hFFFF)) begin
            fetch_stall_cnt_d = fetch_stall_cnt_q + 16'd1;
        end else begin
            fetch_stall_cnt_d = fetch_stall_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk1_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            conflict_cnt_q    <= 16'd0;
            fetch_stall_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q    <= conflict_cnt_d;
            fetch_stall_cnt_q <= fetch_stall_cnt_d;
        end
    end

    assign conflict_cnt_o    = conflict_cnt_q;
    assign fetch_stall_cnt_o = fetch_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Self-checking bench for mips_mem_port_arbiter.
// A queue-driven requester model feeds the IF and MEM ports. A bench memory
// answers on the memory port with a programmable latency. Expected grants
// and read data are queued when the stimulus is issued and compared when
// the DUT produces them.
module tb_mips_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, m_ack_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0, d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0, m_rdata_i = '0;
    logic          if_ready_o, if_stall_o, d_ready_o, d_stall_o, m_req_o, m_we_o;
    logic [DW-1:0] if_rdata_o, d_rdata_o, m_wdata_o;
    logic [AW-1:0] m_addr_o;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt_o, fetch_stall_cnt_o;
`endif

    always #5 clk1 = ~clk1;

    mips_mem_port_arbiter dut (
        .clk1_i(clk1), .rst_n_i(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
        .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt_o(conflict_cnt_o), .fetch_stall_cnt_o(fetch_stall_cnt_o)
`endif
    );

    logic [DW-1:0] mem [1024];
    req_t          if_pend[$], d_pend[$], exp_grant[$];
    logic [DW-1:0] exp_if[$], exp_d[$];
    logic [DW-1:0] d_model = '0;
    int            n_chk = 0, n_fail = 0, cycle = 0;
    int            lat = 1, ack_extra = 0, hold_left = 0, lat_cnt = 0, ack_cyc = 0;
    bit            mreq_seen = 1'b0;
    logic          prev_if_rdy = 1'b0, prev_d_rdy = 1'b0;

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    task automatic chk_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic exp_gnt(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd;
        exp_grant.push_back(r);
    endtask

    task automatic push_if(input logic [AW-1:0] a, input logic [DW-1:0] e);
        req_t r;
        r.addr = a; r.we = 1'b0; r.wdata = '0;
        if_pend.push_back(r);
        exp_if.push_back(e);
        if (if_pend.size() == 1) begin
            if_req_i = 1'b1; if_addr_i = a;
        end
    endtask

    task automatic push_d(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                          input logic [DW-1:0] load_val);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd;
        d_pend.push_back(r);
        if (!we) d_model = load_val;
        exp_d.push_back(d_model);
        if (d_pend.size() == 1) begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = a; d_wdata_i = wd;
        end
    endtask

    // One clock: sample outputs, run the memory responder and the requesters.
    task automatic tick();
        req_t g;
        logic [DW-1:0] e;
        @(posedge clk1); #1;
        cycle++;
        chk_eq("if_stall", if_stall_o, if_req_i & ~if_ready_o);
        chk_eq("d_stall", d_stall_o, d_req_i & ~d_ready_o);
        // memory responder
        if (m_ack_i) begin
            if (hold_left > 0) begin
                hold_left--; m_rdata_i = 32'hBAD0BAD0;
            end else begin
                m_ack_i = 1'b0;
            end
        end else if (m_req_o) begin
            if (!mreq_seen) begin
                mreq_seen = 1'b1; lat_cnt = 0;
                if (exp_grant.size() == 0) chk_eq("gnt_unexp", 1, 0);
                else begin
                    g = exp_grant.pop_front();
                    chk_eq("m_addr", m_addr_o, g.addr);
                    chk_eq("m_we", m_we_o, g.we);
                    if (g.we) chk_eq("m_wdata", m_wdata_o, g.wdata);
                end
            end
            if (lat_cnt >= lat) begin
                m_ack_i = 1'b1; m_rdata_i = mem[m_addr_o];
                if (m_we_o) mem[m_addr_o] = m_wdata_o;
                mreq_seen = 1'b0; hold_left = ack_extra; ack_cyc = cycle;
            end else begin
                lat_cnt++;
            end
        end
        // fetch requester
        if (if_ready_o) begin
            chk_eq("if_rdy_pulse", prev_if_rdy, 0);
            chk_eq("if_rdy_lat", cycle - ack_cyc, 1);
            if (exp_if.size() == 0) chk_eq("if_rdy_unexp", 1, 0);
            else begin e = exp_if.pop_front(); chk_eq("if_rdata", if_rdata_o, e); end
            if (if_pend.size() > 0) void'(if_pend.pop_front());
            if (if_pend.size() > 0) if_addr_i = if_pend[0].addr;
            else if_req_i = 1'b0;
        end
        // data requester
        if (d_ready_o) begin
            chk_eq("d_rdy_pulse", prev_d_rdy, 0);
            chk_eq("d_rdy_lat", cycle - ack_cyc, 1);
            if (exp_d.size() == 0) chk_eq("d_rdy_unexp", 1, 0);
            else begin e = exp_d.pop_front(); chk_eq("d_rdata", d_rdata_o, e); end
            if (d_pend.size() > 0) void'(d_pend.pop_front());
            if (d_pend.size() > 0) begin
                d_we_i = d_pend[0].we; d_addr_i = d_pend[0].addr; d_wdata_i = d_pend[0].wdata;
            end else begin
                d_req_i = 1'b0;
            end
        end
        prev_if_rdy = if_ready_o;
        prev_d_rdy  = d_ready_o;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((if_pend.size() > 0 || d_pend.size() > 0 || exp_grant.size() > 0 ||
                m_req_o || m_ack_i) && n < budget) begin
            tick(); n++;
        end
        chk_eq("done_in_budget", (n < budget), 1);
        tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        chk_eq("rst_m_req", m_req_o, 0);
        chk_eq("rst_m_we", m_we_o, 0);
        chk_eq("rst_m_addr", m_addr_o, 0);
        chk_eq("rst_if_ready", if_ready_o, 0);
        chk_eq("rst_d_ready", d_ready_o, 0);
        chk_eq("rst_if_rdata", if_rdata_o, 0);
        chk_eq("rst_d_rdata", d_rdata_o, 0);
        rst_n = 1'b1;
        tick();

        // single fetch, ack two cycles after m_req
        mem[5] = 32'hDEADBEEF; lat = 2;
        exp_gnt(10'h005, 1'b0, 32'h0);
        push_if(10'h005, 32'hDEADBEEF);
        wait_done(50);
        chk_eq("t2_if_rdata", if_rdata_o, 32'hDEADBEEF);

        // simultaneous requests: data first, then fetch
        lat = 1;
        exp_gnt(10'h010, 1'b0, 32'h0);
        exp_gnt(10'h001, 1'b0, 32'h0);
        push_d(10'h010, 1'b0, 32'h0, pat(16));
        push_if(10'h001, pat(1));
        wait_done(50);

        // store leaves d_rdata alone, then read it back
        exp_gnt(10'h020, 1'b1, 32'h00001234);
        push_d(10'h020, 1'b1, 32'h00001234, 32'h0);
        wait_done(50);
        chk_eq("t5_d_hold", d_rdata_o, pat(16));
        exp_gnt(10'h020, 1'b0, 32'h0);
        push_d(10'h020, 1'b0, 32'h0, 32'h00001234);
        wait_done(50);

        // streak limit: 4 data grants, one fetch, then remaining data
        lat = 0;
        for (int k = 0; k < 4; k++) exp_gnt(AW'(10'h100 + k), 1'b0, 32'h0);
        exp_gnt(10'h040, 1'b0, 32'h0);
        for (int k = 4; k < 6; k++) exp_gnt(AW'(10'h100 + k), 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) push_d(AW'(10'h100 + k), 1'b0, 32'h0, pat(256 + k));
        push_if(10'h040, pat(64));
        wait_done(200);

        // spurious ack in IDLE
        m_ack_i = 1'b1; m_rdata_i = 32'h55555555;
        repeat (3) tick();
        chk_eq("t6_idle_if_hold", if_rdata_o, pat(64));
        chk_eq("t6_idle_d_hold", d_rdata_o, pat(261));

        // ack held into RESP with different data
        lat = 1; ack_extra = 1;
        exp_gnt(10'h007, 1'b0, 32'h0);
        push_if(10'h007, pat(7));
        wait_done(50);
        repeat (2) tick();
        chk_eq("t6_resp_if_hold", if_rdata_o, pat(7));
        chk_eq("t6_resp_d_hold", d_rdata_o, pat(261));
        ack_extra = 0;

        // async reset during an access
        lat = 6;
        exp_gnt(10'h0AA, 1'b0, 32'h0);
        push_if(10'h0AA, 32'h0);
        n = 0;
        while (!m_req_o && n < 20) begin tick(); n++; end
        chk_eq("t1_m_req_up", m_req_o, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t1_m_req_async", m_req_o, 0);
        chk_eq("t1_if_ready", if_ready_o, 0);
        chk_eq("t1_if_rdata", if_rdata_o, 0);
        chk_eq("t1_d_rdata", d_rdata_o, 0);
        chk_eq("t1_m_addr", m_addr_o, 0);
        if_pend.delete(); exp_if.delete(); exp_grant.delete();
        if_req_i = 1'b0; m_ack_i = 1'b0; mreq_seen = 1'b0; d_model = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        lat = 1;
        exp_gnt(10'h003, 1'b0, 32'h0);
        push_if(10'h003, pat(3));
        wait_done(50);
        chk_eq("t1_after_rst", if_rdata_o, pat(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
